// File: rtl/inst_cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int WORD_OFF_W = 2;
    localparam int LINE_OFF_W = 4;
    localparam int LINE_WORDS = 4;

    typedef enum logic [0:0] {
        IcIdle   = 1'b0,
        IcRefill = 1'b1
    } ic_state_e;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/inst_cache_mem.sv
// Valid/tag/data register arrays of the instruction cache with a combinational
// read port, a word write port, a tag/valid write port and flush-all.
module inst_cache_mem
    import inst_cache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 32 - INDEX_W - LINE_OFF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [1:0]         rd_offset,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               word_we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [1:0]         wr_offset,
    input  logic [31:0]        wr_data,
    input  logic               tag_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               set_valid
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES][LINE_WORDS];

    // Flush wins over a same-edge tag write so a flushed refill never goes valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= set_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data[wr_index][wr_offset] <= wr_data;
        end
        if (tag_we) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index][rd_offset];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: zero-latency hits, 4-word line refill over a
// req/ack word handshake while stalling the core's fetch stage.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 32 - INDEX_W - LINE_OFF_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    ic_state_e state;
    logic [1:0] cnt;
    logic       poison;

    logic [1:0]         offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               unused_byte_bits;

    assign offset           = addr_i[3:2];
    assign index            = addr_i[INDEX_W+3:LINE_OFF_W];
    assign tag              = addr_i[31:INDEX_W+LINE_OFF_W];
    assign unused_byte_bits = ^addr_i[1:0];

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_data;
    logic               hit;
    logic               ack;

    assign hit     = ce_i && (state == IcIdle) && rd_valid && (rd_tag == tag);
    assign stall_o = (state == IcRefill) || (ce_i && !hit);
    assign inst_o  = hit ? rd_data : 32'd0;
    assign ack     = (state == IcRefill) && mem_ack_i;

    // During a refill mem_addr_o carries the latched line base, so its upper
    // bits double as the write index and tag.
    inst_cache_mem #(
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_i),
        .rd_index (index),
        .rd_offset(offset),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .word_we  (ack),
        .wr_index (mem_addr_o[INDEX_W+3:LINE_OFF_W]),
        .wr_offset(cnt),
        .wr_data  (mem_data_i),
        .tag_we   (ack && (cnt == 2'd3)),
        .wr_tag   (mem_addr_o[31:INDEX_W+LINE_OFF_W]),
        .set_valid(!poison)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IcIdle;
            cnt        <= 2'd0;
            poison     <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'd0;
        end else if (state == IcIdle) begin
            if (ce_i && !hit) begin
                state      <= IcRefill;
                cnt        <= 2'd0;
                poison     <= 1'b0;
                mem_req_o  <= 1'b1;
                mem_addr_o <= line_base(addr_i);
            end
        end else begin
            if (flush_i) begin
                poison <= 1'b1;
            end
            if (mem_ack_i) begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state      <= IcIdle;
                    poison     <= 1'b0;
                    mem_req_o  <= 1'b0;
                    mem_addr_o <= 32'd0;
                end else begin
                    mem_addr_o <= mem_addr_o + 32'd4;
                end
            end
        end
    end

endmodule
